// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared MIPS datapath.
// Optional feature: define MCTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes.

`ifndef INSTR_OP_RTYPE
`define INSTR_OP_RTYPE 6'h00
`define INSTR_OP_BEQ   6'h04
`define INSTR_OP_BNE   6'h05
`define INSTR_OP_ADDI  6'h08
`define INSTR_OP_ADDIU 6'h09
`define INSTR_OP_SLTI  6'h0A
`define INSTR_OP_SLTIU 6'h0B
`define INSTR_OP_ANDI  6'h0C
`define INSTR_OP_ORI   6'h0D
`define INSTR_OP_XORI  6'h0E
`define INSTR_OP_LUI   6'h0F
`define INSTR_OP_LW    6'h23
`define INSTR_OP_SW    6'h2B
`endif

`ifndef INSTR_FUNCT_ADD
`define INSTR_FUNCT_ADD  6'h20
`define INSTR_FUNCT_ADDU 6'h21
`define INSTR_FUNCT_SUB  6'h22
`define INSTR_FUNCT_SUBU 6'h23
`define INSTR_FUNCT_AND  6'h24
`define INSTR_FUNCT_OR   6'h25
`define INSTR_FUNCT_XOR  6'h26
`define INSTR_FUNCT_NOR  6'h27
`define INSTR_FUNCT_SLT  6'h2A
`define INSTR_FUNCT_SLTU 6'h2B
`endif

`ifndef ALUOp_ADD
`define ALUOp_ADD  5'd0
`define ALUOp_ADDU 5'd1
`define ALUOp_SUB  5'd2
`define ALUOp_SUBU 5'd3
`define ALUOp_AND  5'd4
`define ALUOp_OR   5'd5
`define ALUOp_XOR  5'd6
`define ALUOp_NOR  5'd7
`define ALUOp_SLT  5'd8
`define ALUOp_SLTU 5'd9
`define ALUOp_LUI  5'd10
`define ALUOp_EQL  5'd11
`define ALUOp_BNE  5'd12
`endif

`ifndef SEL_WB_ALUOUT
`define SEL_WB_ALUOUT 2'd0
`define SEL_WB_DM     2'd1
`define SEL_REGDST_RT 2'd0
`define SEL_REGDST_RD 2'd1
`define EXT_MODE_UNSIGNED 1'b0
`define EXT_MODE_SIGNED   1'b1
`endif

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       memReady,
  output logic       ctrlPCWrite,
  output logic       ctrlBranch,
  output logic       ctrlTargetWrite,
  output logic       ctrlIRWrite,
  output logic       ctrlIorD,
  output logic       ctrlMemRead,
  output logic       ctrlMemWrite,
  output logic [1:0] ctrlMemToReg,
  output logic [1:0] ctrlRegDst,
  output logic       ctrlRegWrite,
  output logic       ctrlALUSrcA,
  output logic [1:0] ctrlALUSrcB,
  output logic       ctrlImmExtend,
  output logic [4:0] outALUOp,
  output logic [2:0] state,
  output logic       illegalInstr
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic       w_rtype;
  logic       w_imm;
  logic       w_lw;
  logic       w_sw;
  logic       w_br;
  logic       w_known;
  logic [4:0] w_immOp;
  logic       w_immExt;
  logic [4:0] w_rOp;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  assign state = r_state;

  // Opcode class and immediate op/extension pairing
  always_comb begin
    w_rtype  = 1'b0;
    w_imm    = 1'b0;
    w_lw     = 1'b0;
    w_sw     = 1'b0;
    w_br     = 1'b0;
    w_immOp  = `ALUOp_ADDU;
    w_immExt = `EXT_MODE_UNSIGNED;
    case (opcode)
      `INSTR_OP_RTYPE: w_rtype = 1'b1;
      `INSTR_OP_BEQ:   w_br = 1'b1;
      `INSTR_OP_BNE:   w_br = 1'b1;
      `INSTR_OP_LW:    w_lw = 1'b1;
      `INSTR_OP_SW:    w_sw = 1'b1;
      `INSTR_OP_ADDI: begin
        w_imm    = 1'b1;
        w_immOp  = `ALUOp_ADD;
        w_immExt = `EXT_MODE_SIGNED;
      end
      `INSTR_OP_ADDIU: begin
        w_imm   = 1'b1;
        w_immOp = `ALUOp_ADDU;
      end
      `INSTR_OP_ANDI: begin
        w_imm   = 1'b1;
        w_immOp = `ALUOp_AND;
      end
      `INSTR_OP_ORI: begin
        w_imm   = 1'b1;
        w_immOp = `ALUOp_OR;
      end
      `INSTR_OP_XORI: begin
        w_imm   = 1'b1;
        w_immOp = `ALUOp_XOR;
      end
      `INSTR_OP_LUI: begin
        w_imm   = 1'b1;
        w_immOp = `ALUOp_LUI;
      end
      `INSTR_OP_SLTI: begin
        w_imm   = 1'b1;
        w_immOp = `ALUOp_SLT;
      end
      `INSTR_OP_SLTIU: begin
        w_imm    = 1'b1;
        w_immOp  = `ALUOp_SLTU;
        w_immExt = `EXT_MODE_SIGNED;
      end
      default: ;
    endcase
  end

  assign w_known = w_rtype | w_imm | w_lw | w_sw | w_br;

  // Unlisted R-type funct falls back to ADDU
  always_comb begin
    case (funct)
      `INSTR_FUNCT_ADD:  w_rOp = `ALUOp_ADD;
      `INSTR_FUNCT_ADDU: w_rOp = `ALUOp_ADDU;
      `INSTR_FUNCT_SUB:  w_rOp = `ALUOp_SUB;
      `INSTR_FUNCT_SUBU: w_rOp = `ALUOp_SUBU;
      `INSTR_FUNCT_AND:  w_rOp = `ALUOp_AND;
      `INSTR_FUNCT_OR:   w_rOp = `ALUOp_OR;
      `INSTR_FUNCT_XOR:  w_rOp = `ALUOp_XOR;
      `INSTR_FUNCT_NOR:  w_rOp = `ALUOp_NOR;
      `INSTR_FUNCT_SLT:  w_rOp = `ALUOp_SLT;
      `INSTR_FUNCT_SLTU: w_rOp = `ALUOp_SLTU;
      default:           w_rOp = `ALUOp_ADDU;
    endcase
  end

  always_comb begin
    w_next          = r_state;
    ctrlPCWrite     = 1'b0;
    ctrlBranch      = 1'b0;
    ctrlTargetWrite = 1'b0;
    ctrlIRWrite     = 1'b0;
    ctrlIorD        = 1'b0;
    ctrlMemRead     = 1'b0;
    ctrlMemWrite    = 1'b0;
    ctrlMemToReg    = 2'd0;
    ctrlRegDst      = 2'd0;
    ctrlRegWrite    = 1'b0;
    ctrlALUSrcA     = 1'b0;
    ctrlALUSrcB     = 2'd0;
    ctrlImmExtend   = 1'b0;
    outALUOp        = 5'd0;
    case (r_state)
      S_FETCH: begin
        ctrlMemRead = 1'b1;
        ctrlALUSrcB = 2'd1;
        outALUOp    = `ALUOp_ADDU;
        if (memReady) begin
          ctrlIRWrite = 1'b1;
          ctrlPCWrite = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrlALUSrcB     = 2'd3;
        ctrlImmExtend   = `EXT_MODE_SIGNED;
        outALUOp        = `ALUOp_ADD;
        ctrlTargetWrite = 1'b1;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        w_next = w_known ? S_EXEC : S_TRAP;
`else
        w_next = w_known ? S_EXEC : S_FETCH;
`endif
      end
      S_EXEC: begin
        ctrlALUSrcA = 1'b1;
        unique case (1'b1)
          w_rtype: outALUOp = w_rOp;
          w_imm: begin
            ctrlALUSrcB   = 2'd2;
            outALUOp      = w_immOp;
            ctrlImmExtend = w_immExt;
          end
          w_lw, w_sw: begin
            ctrlALUSrcB   = 2'd2;
            outALUOp      = `ALUOp_ADD;
            ctrlImmExtend = `EXT_MODE_SIGNED;
          end
          w_br: begin
            ctrlBranch = 1'b1;
            outALUOp   = (opcode == `INSTR_OP_BEQ) ?
                         `ALUOp_EQL : `ALUOp_BNE;
          end
          default: ;
        endcase
        if (w_lw | w_sw) w_next = S_MEM;
        else if (w_br)   w_next = S_FETCH;
        else             w_next = S_WB;
      end
      S_MEM: begin
        ctrlIorD     = 1'b1;
        ctrlMemRead  = w_lw;
        ctrlMemWrite = w_sw;
        if (memReady) w_next = w_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        ctrlRegWrite = 1'b1;
        ctrlRegDst   = w_rtype ? `SEL_REGDST_RD : `SEL_REGDST_RT;
        ctrlMemToReg = w_lw ? `SEL_WB_DM : `SEL_WB_ALUOUT;
        w_next       = S_FETCH;
      end
`ifdef MCTRL_ILLEGAL_TRAP_EN
      S_TRAP:  w_next = S_TRAP;
`else
      S_TRAP:  w_next = S_FETCH;
`endif
      default: w_next = S_FETCH;
    endcase
    // Reset cycle drops every request, including a pending memory access
    if (rst) begin
      ctrlPCWrite     = 1'b0;
      ctrlBranch      = 1'b0;
      ctrlTargetWrite = 1'b0;
      ctrlIRWrite     = 1'b0;
      ctrlIorD        = 1'b0;
      ctrlMemRead     = 1'b0;
      ctrlMemWrite    = 1'b0;
      ctrlMemToReg    = 2'd0;
      ctrlRegDst      = 2'd0;
      ctrlRegWrite    = 1'b0;
      ctrlALUSrcA     = 1'b0;
      ctrlALUSrcB     = 2'd0;
      ctrlImmExtend   = 1'b0;
      outALUOp        = 5'd0;
    end
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign illegalInstr = !rst && (r_state == S_TRAP);
`else
  assign illegalInstr = 1'b0;
`endif

endmodule
